// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write, read, reserve ports.
// master drives requests, slave is the register file.
interface register_file_mp_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2
);
  logic [NUM_WR-1:0]              wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr;
  logic [NUM_WR*WIDTH-1:0]        wr_data;
  logic [NUM_WR*(WIDTH/8)-1:0]    wr_be;
  logic [NUM_RD-1:0]              rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD*WIDTH-1:0]        rd_data;
  logic [NUM_RD-1:0]              rd_busy;
  logic [NUM_RD-1:0]              rd_perr;
  logic                           rsv_en;
  logic [ADDR_WIDTH-1:0]          rsv_addr;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rd_perr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, rd_perr
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: byte-merged writes, bypass, busy scoreboard.
// Optional per-byte parity storage enabled by defining RF_PARITY_EN.
module register_file_mp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input logic clk,
  input logic rst_n,
  register_file_mp_if.slave bus
);
  localparam int NB = WIDTH / 8;

  typedef logic [WIDTH-1:0]      word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  word_t            mem    [DEPTH];
  word_t            mem_nx [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_clr;
  logic [DEPTH-1:0] busy_nx;
  logic [NUM_WR-1:0] wr_ok;

  word_t             rdat_nx [NUM_RD];
  logic [NUM_RD-1:0] rbsy_nx;
  logic [NUM_RD-1:0] rper_nx;

  function automatic logic addr_ok(input addr_t a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [NB-1:0] par_of(input word_t w);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^w[b*8 +: 8];
    return p;
  endfunction

`ifdef RF_PARITY_EN
  logic [NB-1:0] par [DEPTH];
`endif

  // Merge all write ports into next entry state; higher port wins per byte.
  always_comb begin
    for (int k = 0; k < NUM_WR; k++)
      wr_ok[k] = bus.wr_en[k] &&
                 addr_ok(bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
    for (int e = 0; e < DEPTH; e++) begin
      mem_nx[e]   = mem[e];
      busy_clr[e] = busy[e];
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k] &&
            int'(bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) == e) begin
          busy_clr[e] = 1'b0;
          for (int b = 0; b < NB; b++)
            if (bus.wr_be[k*NB + b])
              mem_nx[e][b*8 +: 8] = bus.wr_data[k*WIDTH + b*8 +: 8];
        end
      end
    end
    busy_nx = busy_clr;
    if (bus.rsv_en && addr_ok(bus.rsv_addr))
      for (int e = 0; e < DEPTH; e++)
        if (int'(bus.rsv_addr) == e) busy_nx[e] = 1'b1;
  end

  // Read mux on post-write state gives write-first bypass.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rdat_nx[i] = '0;
      rbsy_nx[i] = 1'b0;
      rper_nx[i] = 1'b0;
      if (addr_ok(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (int'(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) == e) begin
            rdat_nx[i] = mem_nx[e];
            rbsy_nx[i] = busy_clr[e];
`ifdef RF_PARITY_EN
            rper_nx[i] = |(par[e] ^ par_of(mem[e]));
            for (int k = 0; k < NUM_WR; k++)
              if (wr_ok[k] &&
                  int'(bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) == e)
                rper_nx[i] = 1'b0;
`endif
          end
        end
      end
    end
  end

  // Storage and scoreboard update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      busy <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= mem_nx[e];
      busy <= busy_nx;
    end
  end

`ifdef RF_PARITY_EN
  // Parity computed after the byte merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) par[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        if (mem_nx[e] != mem[e]) par[e] <= par_of(mem_nx[e]);
    end
  end
`else
  logic unused_par;
  assign unused_par = ^par_of('0) ^ ^rper_nx;
`endif

  // Registered read outputs, held while rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
      bus.rd_busy <= '0;
`ifdef RF_PARITY_EN
      bus.rd_perr <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i]) begin
          bus.rd_data[i*WIDTH +: WIDTH] <= rdat_nx[i];
          bus.rd_busy[i]                <= rbsy_nx[i];
`ifdef RF_PARITY_EN
          bus.rd_perr[i]                <= rper_nx[i];
`endif
        end
      end
    end
  end

`ifndef RF_PARITY_EN
  assign bus.rd_perr = '0;
`endif
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with a queue scoreboard.
// Stimulus pushes expected reads; a monitor pops them after each edge.
module tb_register_file_mp;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 6;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int NB = W / 8;

  typedef struct {
    logic [W-1:0] data;
    logic         busy;
    logic         perr;
    int           addr;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sbq [NR][$];

  always #5 clk = ~clk;

  register_file_mp_if #(.WIDTH(W), .ADDR_WIDTH(AW),
    .NUM_RD(NR), .NUM_WR(NW)) bus ();

  register_file_mp #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW),
    .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic wr(input int k, input int a,
                    input logic [W-1:0] d, input logic [NB-1:0] be);
    bus.wr_en[k]              = 1'b1;
    bus.wr_addr[k*AW +: AW]   = AW'(a);
    bus.wr_data[k*W +: W]     = d;
    bus.wr_be[k*NB +: NB]     = be;
  endtask

  task automatic rd(input int p, input int a,
                    input logic [W-1:0] d, input logic b);
    exp_t e;
    e.data = d; e.busy = b; e.perr = 1'b0; e.addr = a;
    bus.rd_en[p]            = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(a);
    sbq[p].push_back(e);
  endtask

  task automatic rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: compare every read that was enabled at the last edge.
  initial begin
    logic [NR-1:0] en_s;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s = bus.rd_en;
      #1;
      if (rst_n) begin
        for (int p = 0; p < NR; p++) begin
          if (en_s[p]) begin
            if (sbq[p].size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL sb_underflow p%0d", p);
            end else begin
              e = sbq[p].pop_front();
              n_vec++;
              if (bus.rd_data[p*W +: W] !== e.data ||
                  bus.rd_busy[p] !== e.busy ||
                  bus.rd_perr[p] !== e.perr) begin
                n_bad++;
                $display("FAIL rd p%0d a%0d: got %h/%b/%b want %h/%b/%b",
                  p, e.addr, bus.rd_data[p*W +: W], bus.rd_busy[p],
                  bus.rd_perr[p], e.data, e.busy, e.perr);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #12;
    chk("reset_rd_data", bus.rd_data, '0);
    chk("reset_rd_busy", {29'd0, bus.rd_busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int e = 0; e < D; e++) begin
      rd(0, e, '0, 1'b0);
      rd(1, (e + 11) % D, '0, 1'b0);
      rd(2, D - 1 - e, '0, 1'b0);
      tick();
    end

    wr(0, 5, 32'hDEADBEEF, 4'hF); tick();
    rd(0, 5, 32'hDEADBEEF, 1'b0); tick();

    wr(0, 7, 32'h11111111, 4'hF);
    wr(1, 7, 32'h22222222, 4'h3);
    rd(1, 7, 32'h11112222, 1'b0); tick();
    rd(2, 7, 32'h11112222, 1'b0); tick();

    wr(0, 0, 32'hFFFFFFFF, 4'hF);
    wr(1, 33, 32'h12345678, 4'hF);
    rd(0, 0, '0, 1'b0);
    rd(1, 33, '0, 1'b0); tick();
    rd(0, 0, '0, 1'b0);
    rd(1, 33, '0, 1'b0);
    rd(2, 1, '0, 1'b0); tick();

    rsv(9); tick();
    rd(0, 9, '0, 1'b1);
    rd(1, 9, '0, 1'b1); tick();
    wr(0, 9, 32'h000000AB, 4'hF);
    rd(2, 9, 32'h000000AB, 1'b0); tick();
    rd(0, 9, 32'h000000AB, 1'b0); tick();
    rsv(9);
    wr(1, 9, 32'h000000CD, 4'h1);
    rd(0, 9, 32'h000000CD, 1'b0); tick();
    rd(0, 9, 32'h000000CD, 1'b1); tick();

    wr(0, 5, 32'h00550000, 4'h4);
    wr(1, 7, 32'hFFFFFFFF, 4'h0);
    rd(0, 5, 32'hDE55BEEF, 1'b0); tick();
    rd(1, 7, 32'h11112222, 1'b0); tick();
    rd(2, 5, 32'hDE55BEEF, 1'b0); tick();
    tick();
    chk("hold_p0", bus.rd_data[0 +: W], 32'hDE55BEEF);
    chk("hold_p2", bus.rd_data[2*W +: W], 32'hDE55BEEF);

    rsv(40); tick();
    rsv(0); tick();
    rd(0, 0, '0, 1'b0);
    rd(1, 12, '0, 1'b0); tick();

    wr(0, 5, 32'hCAFEF00D, 4'hF);
    rsv(12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", bus.rd_data, '0);
    chk("async_rst_busy", {29'd0, bus.rd_busy}, '0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, 5, '0, 1'b0);
    rd(1, 12, '0, 1'b0);
    rd(2, 9, '0, 1'b0); tick();
    tick();

    for (int p = 0; p < NR; p++) begin
      n_vec++;
      if (sbq[p].size() != 0) begin
        n_bad++;
        $display("FAIL sb_leftover p%0d: %0d left want 0",
          p, sbq[p].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
